// File: rtl/sseg_mux_driver.sv
// sseg_mux_driver: time-multiplexed N-digit seven-segment driver for a
// common-anode display. It decodes hex nibbles, drives a decimal point per
// digit and applies a per-digit enable mask. All display outputs are
// active-low and registered.
//
// The i_load strobe captures a complete display word into a pending buffer.
// That word moves into the active buffer only at a frame wrap, so a frame
// never shows a mix of old and new digits.
//
// Optional feature, selected by the macro SSEG_GHOST_BLANK_EN:
// blanks the last BLANK_TICKS output cycles of every digit slot to suppress
// ghosting. When the macro is undefined, BLANK_TICKS has no effect.
module sseg_mux_driver #(
  parameter int N_DIGITS        = 4,
  parameter int TICKS_PER_DIGIT = 50000,
  parameter int BLANK_TICKS     = 500
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_load,
  input  logic [4*N_DIGITS-1:0] i_hex,
  input  logic [N_DIGITS-1:0]   i_dp,
  input  logic [N_DIGITS-1:0]   i_en,
  output logic [N_DIGITS-1:0]   o_an_n,
  output logic [7:0]            o_sseg_n,
  output logic                  o_digit_tick,
  output logic                  o_frame
);

  localparam int CNT_W = (TICKS_PER_DIGIT > 1) ? $clog2(TICKS_PER_DIGIT) : 1;
  localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICKS_PER_DIGIT - 1);
  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(N_DIGITS - 1);
  localparam int BLANK_START = TICKS_PER_DIGIT - BLANK_TICKS;
`ifdef SSEG_GHOST_BLANK_EN
  localparam bit BLANK_EN = 1'b1;
`else
  localparam bit BLANK_EN = 1'b0;
`endif

  // Scan position
  logic [CNT_W-1:0]      r_cnt;
  logic [IDX_W-1:0]      r_idx;

  // Pending word (written by i_load) and active word (shown on the display)
  logic [4*N_DIGITS-1:0] r_pend_hex;
  logic [N_DIGITS-1:0]   r_pend_dp;
  logic [N_DIGITS-1:0]   r_pend_en;
  logic                  r_pend_valid;
  logic [4*N_DIGITS-1:0] r_act_hex;
  logic [N_DIGITS-1:0]   r_act_dp;
  logic [N_DIGITS-1:0]   r_act_en;

  // Registered outputs
  logic [N_DIGITS-1:0]   r_an_n;
  logic [7:0]            r_sseg_n;
  logic                  r_digit_tick;
  logic                  r_frame;

  logic                  w_last;
  logic                  w_wrap;
  logic [3:0]            w_nib;
  logic                  w_digit_on;
  logic                  w_blank;
  logic [31:0]           w_cnt_ext;
  logic [N_DIGITS-1:0]   w_an_sel;

  // Hex to active-low segments, bit order {g,f,e,d,c,b,a}
  function automatic logic [6:0] seg_decode(input logic [3:0] h);
    case (h)
      4'h0: seg_decode = 7'h40;
      4'h1: seg_decode = 7'h79;
      4'h2: seg_decode = 7'h24;
      4'h3: seg_decode = 7'h30;
      4'h4: seg_decode = 7'h19;
      4'h5: seg_decode = 7'h12;
      4'h6: seg_decode = 7'h02;
      4'h7: seg_decode = 7'h78;
      4'h8: seg_decode = 7'h00;
      4'h9: seg_decode = 7'h10;
      4'hA: seg_decode = 7'h08;
      4'hB: seg_decode = 7'h03;
      4'hC: seg_decode = 7'h46;
      4'hD: seg_decode = 7'h21;
      4'hE: seg_decode = 7'h06;
      default: seg_decode = 7'h0E;
    endcase
  endfunction

  assign w_last     = (r_cnt == CNT_MAX);
  assign w_wrap     = w_last && (r_idx == IDX_MAX);
  assign w_nib      = r_act_hex[r_idx*4 +: 4];
  assign w_digit_on = r_act_en[r_idx];
  assign w_an_sel   = ~(N_DIGITS'(1) << r_idx);
  assign w_cnt_ext  = 32'(r_cnt);
  // Dark tail of each slot; BLANK_EN is constant 0 when blanking is compiled out
  assign w_blank    = BLANK_EN && (w_cnt_ext >= 32'(BLANK_START));

  // Slot counter and digit index; the index advances on the last cycle of a slot
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt <= '0;
      r_idx <= '0;
    end else if (w_last) begin
      r_cnt <= '0;
      r_idx <= (r_idx == IDX_MAX) ? '0 : r_idx + 1'b1;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Double buffer. An older pending word is promoted at the wrap.
  // A load issued in the wrap cycle is written after the promotion,
  // so it stays pending until the following wrap.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_pend_hex   <= '0;
      r_pend_dp    <= '0;
      r_pend_en    <= '0;
      r_pend_valid <= 1'b0;
      r_act_hex    <= '0;
      r_act_dp     <= '0;
      r_act_en     <= '1;
    end else begin
      if (w_wrap && r_pend_valid) begin
        r_act_hex    <= r_pend_hex;
        r_act_dp     <= r_pend_dp;
        r_act_en     <= r_pend_en;
        r_pend_valid <= 1'b0;
      end
      if (i_load) begin
        r_pend_hex   <= i_hex;
        r_pend_dp    <= i_dp;
        r_pend_en    <= i_en;
        r_pend_valid <= 1'b1;
      end
    end
  end

  // Output register: anode and segments for the current index, plus the scan pulses
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_an_n       <= '1;
      r_sseg_n     <= 8'hFF;
      r_digit_tick <= 1'b0;
      r_frame      <= 1'b0;
    end else begin
      r_digit_tick <= w_last;
      r_frame      <= w_wrap;
      if (w_digit_on && !w_blank) begin
        r_an_n   <= w_an_sel;
        r_sseg_n <= {~r_act_dp[r_idx], seg_decode(w_nib)};
      end else begin
        r_an_n   <= '1;
        r_sseg_n <= 8'hFF;
      end
    end
  end

  assign o_an_n       = r_an_n;
  assign o_sseg_n     = r_sseg_n;
  assign o_digit_tick = r_digit_tick;
  assign o_frame      = r_frame;

endmodule

// File: tb/tb_sseg_mux_driver.sv
// Testbench for sseg_mux_driver with N_DIGITS=4, TICKS_PER_DIGIT=4,
// BLANK_TICKS=1. On every clock edge a reference model pushes the expected
// output word, and a monitor on the falling edge pops it and compares.
module tb_sseg_mux_driver;

  localparam int N = 4;
  localparam int T = 4;
  localparam int B = 1;
  localparam int EW = N + 8 + 2;

  localparam logic [6:0] SEG_TAB [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  logic           clk;
  logic           i_rst;
  logic           i_load;
  logic [4*N-1:0] i_hex;
  logic [N-1:0]   i_dp;
  logic [N-1:0]   i_en;
  logic [N-1:0]   o_an_n;
  logic [7:0]     o_sseg_n;
  logic           o_digit_tick;
  logic           o_frame;

  logic [EW-1:0] exp_q[$];
  int checks;
  int failures;

  sseg_mux_driver #(
    .N_DIGITS(N),
    .TICKS_PER_DIGIT(T),
    .BLANK_TICKS(B)
  ) dut (
    .i_clk(clk),
    .i_rst(i_rst),
    .i_load(i_load),
    .i_hex(i_hex),
    .i_dp(i_dp),
    .i_en(i_en),
    .o_an_n(o_an_n),
    .o_sseg_n(o_sseg_n),
    .o_digit_tick(o_digit_tick),
    .o_frame(o_frame)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model. The scan position is derived from the number of cycles
  // since reset. The display word is a pair of pending/active copies.
  int             m_cyc;
  logic [4*N-1:0] m_act_hex;
  logic [N-1:0]   m_act_dp;
  logic [N-1:0]   m_act_en;
  logic [4*N-1:0] m_pend_hex;
  logic [N-1:0]   m_pend_dp;
  logic [N-1:0]   m_pend_en;
  bit             m_pend_v;
  int             m_digit;
  int             m_phase;
  logic [N-1:0]   m_an;
  logic [7:0]     m_sseg;
  logic           m_tick;
  logic           m_frame;

  always @(posedge clk) begin
    if (i_rst) begin
      exp_q.push_back({{N{1'b1}}, 8'hFF, 1'b0, 1'b0});
      m_cyc     = 0;
      m_act_hex = '0;
      m_act_dp  = '0;
      m_act_en  = '1;
      m_pend_v  = 1'b0;
    end else begin
      m_digit = (m_cyc / T) % N;
      m_phase = m_cyc % T;
      m_an    = '1;
      m_sseg  = 8'hFF;
      if (m_act_en[m_digit]) begin
        m_an   = ~(4'b0001 << m_digit);
        m_sseg = {~m_act_dp[m_digit], SEG_TAB[m_act_hex[m_digit*4 +: 4]]};
      end
`ifdef SSEG_GHOST_BLANK_EN
      if (m_phase >= T - B) begin
        m_an   = '1;
        m_sseg = 8'hFF;
      end
`endif
      m_tick  = (m_phase == T - 1);
      m_frame = m_tick && (m_digit == N - 1);
      exp_q.push_back({m_an, m_sseg, m_tick, m_frame});
      if (m_frame && m_pend_v) begin
        m_act_hex = m_pend_hex;
        m_act_dp  = m_pend_dp;
        m_act_en  = m_pend_en;
        m_pend_v  = 1'b0;
      end
      if (i_load) begin
        m_pend_hex = i_hex;
        m_pend_dp  = i_dp;
        m_pend_en  = i_en;
        m_pend_v   = 1'b1;
      end
      m_cyc = m_cyc + 1;
    end
  end

  // Monitor: on each falling edge, pops one expected word and compares it field by field
  logic [EW-1:0] mon_exp;
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_exp = exp_q.pop_front();
      checks = checks + 4;
      if (o_an_n !== mon_exp[EW-1 -: N]) begin
        failures = failures + 1;
        $display("FAIL an t=%0t got=%b exp=%b", $time, o_an_n, mon_exp[EW-1 -: N]);
      end
      if (o_sseg_n !== mon_exp[9:2]) begin
        failures = failures + 1;
        $display("FAIL sseg t=%0t got=%h exp=%h", $time, o_sseg_n, mon_exp[9:2]);
      end
      if (o_digit_tick !== mon_exp[1]) begin
        failures = failures + 1;
        $display("FAIL digit_tick t=%0t got=%b exp=%b", $time, o_digit_tick, mon_exp[1]);
      end
      if (o_frame !== mon_exp[0]) begin
        failures = failures + 1;
        $display("FAIL frame t=%0t got=%b exp=%b", $time, o_frame, mon_exp[0]);
      end
    end
  end

  // Driver tasks; they are called just after a falling edge
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_load(input logic [4*N-1:0] hex, input logic [N-1:0] dp,
                         input logic [N-1:0] en);
    i_load = 1'b1;
    i_hex  = hex;
    i_dp   = dp;
    i_en   = en;
    @(negedge clk);
    i_load = 1'b0;
    i_hex  = $urandom();
  endtask

  task automatic do_reset(input int n);
    i_rst = 1'b1;
    idle(n);
    i_rst = 1'b0;
  endtask

  // Waits until the current cycle is the frame-wrap cycle (cycle index 15 of 16)
  task automatic wait_wrap_cycle();
    bit found;
    found = 1'b0;
    for (int k = 0; k < 4 * N * T; k++) begin
      if (m_cyc % (N * T) == N * T - 1) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    checks = checks + 1;
    if (!found) begin
      failures = failures + 1;
      $display("FAIL wrap_wait got=timeout exp=wrap cycle");
    end
  endtask

  // Stimulus
  initial begin
    checks   = 0;
    failures = 0;
    i_rst    = 1'b1;
    i_load   = 1'b0;
    i_hex    = '0;
    i_dp     = '0;
    i_en     = '0;
    idle(3);
    i_rst = 1'b0;

    // Reset display: zeros on every digit
    idle(20);

    // Mid-frame load shows up from the next frame onward
    idle(5);
    do_load(16'hA5F0, 4'b0100, 4'hF);
    idle(40);

    // Two loads in one frame: the last one wins
    wait_wrap_cycle();
    idle(2);
    do_load(16'h1111, 4'h0, 4'hF);
    idle(3);
    do_load(16'h2222, 4'h0, 4'hF);
    idle(40);

    // Load issued on the wrap cycle while an earlier load is still pending
    wait_wrap_cycle();
    idle(3);
    do_load(16'h3333, 4'h0, 4'hF);
    wait_wrap_cycle();
    do_load(16'h4444, 4'b1010, 4'hF);
    idle(40);

    // Enable mask
    do_load(16'h7654, 4'b0011, 4'b0101);
    idle(40);

    // Random loads with random gaps
    for (int r = 0; r < 40; r++) begin
      do_load(16'($urandom()), 4'($urandom()), 4'($urandom()));
      idle($urandom_range(0, 20));
    end
    idle(20);

    // Reset mid-frame with a load pending
    wait_wrap_cycle();
    idle(4);
    do_load(16'h9876, 4'hF, 4'hF);
    idle(2);
    do_reset(1);
    idle(40);

    // Random loads with occasional resets
    for (int r = 0; r < 30; r++) begin
      do_load(16'($urandom()), 4'($urandom()), 4'($urandom()));
      idle($urandom_range(0, 12));
      if ($urandom_range(0, 7) == 0) do_reset($urandom_range(1, 2));
    end
    idle(40);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
